// File: rtl/io_input_port.sv
// io_input_port: handshaked input port that captures the user switches when a
// debounced confirm button is pressed while the processor waits on an IN.
module io_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_req,
    input  logic        in_ack,
    input  logic        button,
    input  logic [15:0] switches,
    output logic        ready,
    output logic [31:0] data_out,
    output logic        waiting
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FULL    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic               sync1;
    logic               sync2;
    logic               btn_db;
    logic [CNT_W-1:0]   counter;

    logic               differ_c;
    logic               toggle_c;
    logic               press_c;

    // Debounce decisions for the current edge; a press is a 0->1 toggle.
    assign differ_c = (sync2 != btn_db);
    assign toggle_c = differ_c && (counter == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press_c  = toggle_c && !btn_db;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db  <= 1'b0;
            counter <= '0;
        end else if (toggle_c) begin
            btn_db  <= ~btn_db;
            counter <= '0;
        end else if (differ_c) begin
            counter <= counter + CNT_W'(1);
        end else begin
            counter <= '0;
        end
    end

    // Request/capture/acknowledge/release sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b0;
            waiting  <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A button still held from before must be released first.
                    if (in_req && !btn_db) begin
                        state   <= ARMED;
                        waiting <= 1'b1;
                    end
                end
                ARMED: begin
                    if (press_c) begin
                        state    <= FULL;
                        ready    <= 1'b1;
                        waiting  <= 1'b0;
                        data_out <= {(DATA_W - SW_W)'(0), switches};
                    end else if (!in_req) begin
                        state   <= IDLE;
                        waiting <= 1'b0;
                    end
                end
                FULL: begin
                    if (in_ack) begin
                        state <= RELEASE;
                        ready <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!btn_db && !in_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready   <= 1'b0;
                    waiting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed and random checks of io_input_port against a
// behavioural model of the port (N = 4).
module tb_io_input_port;

    localparam int unsigned N = 4;

    logic        clk;
    logic        reset;
    logic        in_req;
    logic        in_ack;
    logic        button;
    logic [15:0] switches;
    logic        ready;
    logic [31:0] data_out;
    logic        waiting;

    int tests_run;
    int tests_failed;

    // Behavioural model state
    logic        m_hist [2];   // button as seen one and two edges ago
    logic        m_level;      // accepted button level
    int          m_run;        // consecutive edges the seen level disagreed
    int          m_state;      // 0 idle, 1 armed, 2 full, 3 release
    logic [31:0] m_data;

    io_input_port #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .button   (button),
        .switches (switches),
        .ready    (ready),
        .data_out (data_out),
        .waiting  (waiting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        logic lvl_before;
        logic press;
        if (reset) begin
            m_hist[0] = 1'b0;
            m_hist[1] = 1'b0;
            m_level   = 1'b0;
            m_run     = 0;
            m_state   = 0;
            m_data    = 32'h0;
        end else begin
            lvl_before = m_level;
            press      = 1'b0;
            if (m_hist[1] != m_level) begin
                m_run = m_run + 1;
                if (m_run == int'(N)) begin
                    press   = !m_level;
                    m_level = !m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            case (m_state)
                0: if (in_req && !lvl_before) m_state = 1;
                1: begin
                    if (press) begin
                        m_state = 2;
                        m_data  = {16'h0, switches};
                    end else if (!in_req) begin
                        m_state = 0;
                    end
                end
                2: if (in_ack) m_state = 3;
                default: if (!lvl_before && !in_req) m_state = 0;
            endcase
            m_hist[1] = m_hist[0];
            m_hist[0] = button;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_req   = 1'($urandom);
            in_ack   = 1'($urandom);
            button   = 1'($urandom);
            switches = 16'($urandom);
            tick();
            tests_run++;
            if (ready !== 1'b0 || waiting !== 1'b0 || data_out !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset: ready=%b waiting=%b data=%h, want 0 0 0", ready, waiting, data_out);
            end
        end
        reset = 1'b0; in_req = 0; in_ack = 0; button = 0; switches = 0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_capture();
        in_req = 1; switches = 16'hA5C3; button = 1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            tests_run++;
            if (ready !== (e == 6) || waiting !== (e < 6)) begin
                tests_failed++;
                $display("FAIL capture_latency edge %0d: ready=%b waiting=%b, want %b %b",
                         e, ready, waiting, (e == 6), (e < 6));
            end
        end
        tests_run++;
        if (data_out !== 32'h0000A5C3) begin
            tests_failed++;
            $display("FAIL capture_data: got %h want 0000a5c3", data_out);
        end
        switches = 16'hFFFF;
        tick(); tick();
        tests_run++;
        if (data_out !== 32'h0000A5C3 || ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL data_hold: data=%h ready=%b want 0000a5c3 1", data_out, ready);
        end
        in_ack = 1; tick(); in_ack = 0;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack: ready=%b want 0", ready);
        end
        button = 0; in_req = 0;
        for (int i = 0; i < 8; i++) tick();
        in_req = 1; tick();
        tests_run++;
        if (waiting !== 1'b1 || waiting !== (m_state == 1)) begin
            tests_failed++;
            $display("FAIL rearm_after_release: waiting=%b want 1", waiting);
        end
    endtask

    task automatic test_short_pulse();
        // Port is armed from the previous scenario.
        button = 1;
        for (int i = 0; i < 3; i++) tick();
        button = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (ready !== 1'b0 || waiting !== 1'b1 || data_out !== m_data) begin
                tests_failed++;
                $display("FAIL short_pulse cyc %0d: ready=%b waiting=%b data=%h want 0 1 %h",
                         i, ready, waiting, data_out, m_data);
            end
        end
        in_req = 0; tick();
    endtask

    task automatic test_held_before_req();
        button = 1; switches = 16'h1234;
        for (int i = 0; i < 8; i++) tick();
        in_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (ready !== 1'b0 || waiting !== 1'b0) begin
                tests_failed++;
                $display("FAIL held_before_req cyc %0d: ready=%b waiting=%b want 0 0", i, ready, waiting);
            end
        end
        button = 0;
        for (int i = 0; i < 8; i++) tick();
        button = 1; switches = 16'h5A5A;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (ready !== 1'b1 || data_out !== 32'h00005A5A) begin
            tests_failed++;
            $display("FAIL repress_capture: ready=%b data=%h want 1 00005a5a", ready, data_out);
        end
    endtask

    task automatic test_ack_with_press();
        // In FULL: release, then re-press with in_ack landing on the press edge.
        button = 0; switches = 16'hFFFF;
        for (int i = 0; i < 8; i++) tick();
        button = 1;
        for (int i = 0; i < 5; i++) tick();
        in_ack = 1; tick(); in_ack = 0;
        tests_run++;
        if (ready !== 1'b0 || data_out !== 32'h00005A5A || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_with_press: ready=%b data=%h waiting=%b want 0 00005a5a 0",
                     ready, data_out, waiting);
        end
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (ready !== 1'b0 || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_press_one_req: ready=%b waiting=%b want 0 0", ready, waiting);
        end
    endtask

    task automatic test_reset_in_full();
        in_req = 0; button = 0;
        for (int i = 0; i < 8; i++) tick();
        in_req = 1; switches = 16'hBEEF; button = 1;
        for (int i = 0; i < 6; i++) tick();
        reset = 1; tick(); reset = 0;
        tests_run++;
        if (ready !== 1'b0 || data_out !== 32'h0 || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_full: ready=%b data=%h waiting=%b want 0 0 0", ready, data_out, waiting);
        end
        // Button still held: treated as a fresh press after reset.
        switches = 16'h0F0F;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (ready !== 1'b1 || data_out !== 32'h00000F0F) begin
            tests_failed++;
            $display("FAIL fresh_press_after_reset: ready=%b data=%h want 1 00000f0f", ready, data_out);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                button = 1'($urandom);
                hold   = int'($urandom_range(1, 9));
            end
            hold--;
            in_req   = ($urandom_range(0, 9) < 7);
            in_ack   = ($urandom_range(0, 9) < 2);
            switches = 16'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
            tick();
            tests_run++;
            if (ready !== (m_state == 2) || waiting !== (m_state == 1) || data_out !== m_data) begin
                tests_failed++;
                $display("FAIL random cyc %0d: ready=%b waiting=%b data=%h want %b %b %h",
                         i, ready, waiting, data_out, (m_state == 2), (m_state == 1), m_data);
            end
        end
        reset = 0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        m_hist[0] = 0; m_hist[1] = 0;
        m_level = 0; m_run = 0; m_state = 0; m_data = 0;
        reset = 1; in_req = 0; in_ack = 0; button = 0; switches = 0;
        test_reset();
        test_capture();
        test_short_pulse();
        test_held_before_req();
        test_ack_with_press();
        test_reset_in_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
